// File: rtl/sad_disparity_search_pkg.sv
// Shared types and constants for the stereo SAD disparity search.
// Block geometry is fixed at 6x6 pixels of 8 bits.
package stereo_pkg;
  localparam int BLOCK_SIZE = 6;
  localparam int PIX_W      = 8;
  localparam int ROW_W      = 48;
  localparam int SAD_W      = 14;
  localparam int ROW_SAD_W  = 11;

  typedef logic [BLOCK_SIZE-1:0][ROW_W-1:0] block_t;
  typedef logic [SAD_W-1:0]                 sad_t;
  typedef logic [ROW_SAD_W-1:0]             row_sad_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACC,
    S_CMP,
    S_DONE
  } search_state_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/sad_disparity_search_row_sad.sv
// Combinational SAD of one 6-pixel row pair (max 6*255 = 1530).
module row_sad
  import stereo_pkg::*;
(
  input  logic [ROW_W-1:0] i_row_a,
  input  logic [ROW_W-1:0] i_row_b,
  output row_sad_t         o_sad
);
  logic [PIX_W-1:0] w_ad [BLOCK_SIZE];

  always_comb begin
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      w_ad[k] = abs_diff(i_row_a[PIX_W*k +: PIX_W], i_row_b[PIX_W*k +: PIX_W]);
    end
  end

  assign o_sad = (row_sad_t'(w_ad[0]) + row_sad_t'(w_ad[1]))
               + (row_sad_t'(w_ad[2]) + row_sad_t'(w_ad[3]))
               + (row_sad_t'(w_ad[4]) + row_sad_t'(w_ad[5]));
endmodule

// File: rtl/sad_disparity_search.sv
// Stereo block matcher: sweeps disparities for one 6x6 left block, keeps min SAD.
// Optional macro SAD_CONFIDENCE_EN gates disp_valid_out on min SAD <= SAD_THRESH.
module sad_disparity_search
  import stereo_pkg::*;
#(
  parameter  int MAX_DISP   = 16,
  parameter  int SAD_THRESH = 2000,
  localparam int DISP_W     = $clog2(MAX_DISP)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [8:0]        x_in,
  input  logic [9:0]        y_in,
  output logic              busy_out,
  output logic              buf_req_out,
  output logic [8:0]        left_x_req_out,
  output logic [8:0]        right_x_req_out,
  output logic [9:0]        y_req_out,
  input  logic              buf_valid_in,
  input  block_t            left_block_in,
  input  block_t            right_block_in,
  output logic              valid_out,
  output logic [DISP_W-1:0] disparity_out,
  output sad_t              min_sad_out,
  output logic              disp_valid_out
);
  if (MAX_DISP < 2 || SAD_THRESH < 0) begin : g_param_check
    $error("sad_disparity_search: MAX_DISP must be >= 2 and SAD_THRESH >= 0");
  end

  search_state_t     r_state, w_next;
  logic [8:0]        r_x;
  logic [9:0]        r_y;
  logic [DISP_W-1:0] r_d, r_best, r_disp_out;
  sad_t              r_min, r_acc, r_min_out;
  logic [2:0]        r_row;
  block_t            r_left, r_right;
  logic              r_valid;

  row_sad_t          w_row_sad;
  logic              w_better, w_last;
  sad_t              w_min_new;
  logic [DISP_W-1:0] w_best_new;

  row_sad u_row_sad (
    .i_row_a (r_left[r_row]),
    .i_row_b (r_right[r_row]),
    .o_sad   (w_row_sad)
  );

  // Strict compare: ties keep the earlier (smaller) disparity.
  assign w_better   = (r_acc < r_min);
  assign w_min_new  = w_better ? r_acc : r_min;
  assign w_best_new = w_better ? r_d : r_best;
  // Stop at the last candidate or before d would exceed x (left image edge).
  assign w_last = (r_d == DISP_W'(MAX_DISP - 1)) || ((10'(r_d) + 10'd1) > 10'(r_x));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_next = S_REQ;
      S_REQ:   if (buf_valid_in) w_next = S_ACC;
      S_ACC:   if (r_row == 3'd5) w_next = S_CMP;
      S_CMP:   w_next = w_last ? S_DONE : S_REQ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x        <= '0;
      r_y        <= '0;
      r_d        <= '0;
      r_best     <= '0;
      r_min      <= '0;
      r_acc      <= '0;
      r_row      <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_valid    <= 1'b0;
      r_disp_out <= '0;
      r_min_out  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start_in) begin
          r_x    <= x_in;
          r_y    <= y_in;
          r_d    <= '0;
          r_best <= '0;
          r_min  <= '1;
          r_acc  <= '0;
        end
        S_REQ: if (buf_valid_in) begin
          r_left  <= left_block_in;
          r_right <= right_block_in;
          r_row   <= '0;
        end
        S_ACC: begin
          r_acc <= r_acc + sad_t'(w_row_sad);
          r_row <= r_row + 3'd1;
        end
        S_CMP: begin
          r_min  <= w_min_new;
          r_best <= w_best_new;
          if (w_last) begin
            r_valid    <= 1'b1;
            r_disp_out <= w_best_new;
            r_min_out  <= w_min_new;
          end else begin
            r_d   <= r_d + 1'b1;
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SAD_CONFIDENCE_EN
  logic r_conf;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                   r_conf <= 1'b0;
    else if (r_state == S_CMP && w_last) r_conf <= (w_min_new <= sad_t'(SAD_THRESH));
  end

  assign disp_valid_out = r_conf;
`else
  assign disp_valid_out = r_valid;
`endif

  assign busy_out        = (r_state != S_IDLE);
  assign buf_req_out     = (r_state == S_REQ);
  assign left_x_req_out  = r_x;
  assign right_x_req_out = r_x - 9'(r_d);
  assign y_req_out       = r_y;
  assign valid_out       = r_valid;
  assign disparity_out   = r_disp_out;
  assign min_sad_out     = r_min_out;
endmodule

// File: tb/tb_sad_disparity_search.sv
// Self-checking bench: table of searches, block-buffer responder, result scoreboard.
module tb_sad_disparity_search;
  import stereo_pkg::*;

  localparam int MD  = 16;
  localparam int THR = 2000;
  localparam int DW  = $clog2(MD);

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start_in = 1'b0;
  logic [8:0]    x_in = '0;
  logic [9:0]    y_in = '0;
  logic          buf_valid_in = 1'b0;
  block_t        left_block_in = '0;
  block_t        right_block_in = '0;
  logic          busy_out, buf_req_out, valid_out, disp_valid_out;
  logic [8:0]    left_x_req_out, right_x_req_out;
  logic [9:0]    y_req_out;
  logic [DW-1:0] disparity_out;
  sad_t          min_sad_out;

  sad_disparity_search #(.MAX_DISP(MD), .SAD_THRESH(THR)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .x_in            (x_in),
    .y_in            (y_in),
    .busy_out        (busy_out),
    .buf_req_out     (buf_req_out),
    .left_x_req_out  (left_x_req_out),
    .right_x_req_out (right_x_req_out),
    .y_req_out       (y_req_out),
    .buf_valid_in    (buf_valid_in),
    .left_block_in   (left_block_in),
    .right_block_in  (right_block_in),
    .valid_out       (valid_out),
    .disparity_out   (disparity_out),
    .min_sad_out     (min_sad_out),
    .disp_valid_out  (disp_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  typedef struct { int disp; int sad; int conf; } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int x; int y; int mode; int seed; int hold;
    bit use_const; int edisp; int esad;
  } vec_t;

  // Responder state: what the block buffer should serve for the current search.
  int cur_mode = 0, cur_seed = 0, cur_x = 0, cur_y = 0, hold_cycles = 0;
  int req_count = 0, req_run = 0, max_req_run = 0, wait_cnt = 0;
  int rx_log[$];
  int n_valid = 0;
  bit prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int lpix(input int mode, input int seed, input int r, input int k);
    if (mode == 2) return 255;
    return (seed * 37 + r * 11 + k * 5 + 3) & 255;
  endfunction

  function automatic int rpix(input int mode, input int seed, input int d, input int r, input int k);
    int v;
    case (mode)
      0: return lpix(mode, seed, r, k);
      1: return (d == 5) ? lpix(mode, seed, r, k) : (lpix(mode, seed, r, k) ^ 1);
      2: return 0;
      default: begin
        v = seed * 1009 + d * 97 + r * 13 + k * 29;
        return ((v * v) >>> 3) & 255;
      end
    endcase
  endfunction

  function automatic block_t mk_left(input int mode, input int seed);
    block_t b;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 6; k++) b[r][8*k +: 8] = 8'(lpix(mode, seed, r, k));
    return b;
  endfunction

  function automatic block_t mk_right(input int mode, input int seed, input int d);
    block_t b;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 6; k++) b[r][8*k +: 8] = 8'(rpix(mode, seed, d, r, k));
    return b;
  endfunction

  function automatic int blk_sad(input int mode, input int seed, input int d);
    int s = 0;
    int a, b;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 6; k++) begin
        a = lpix(mode, seed, r, k);
        b = rpix(mode, seed, d, r, k);
        s += (a > b) ? (a - b) : (b - a);
      end
    return s;
  endfunction

  task automatic model(input int x, input int mode, input int seed, output int bd, output int bs);
    int s;
    bd = 0;
    bs = 16383;
    for (int d = 0; d < MD && d <= x; d++) begin
      s = blk_sad(mode, seed, d);
      if (s < bs) begin bs = s; bd = d; end
    end
  endtask

  function automatic int conf_of(input int sad);
`ifdef SAD_CONFIDENCE_EN
    return (sad <= THR) ? 1 : 0;
`else
    return (sad >= 0) ? 1 : 0;
`endif
  endfunction

  // Block-buffer stand-in: serves REQ after hold_cycles, drives junk with valid high otherwise.
  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        buf_valid_in = 1'b0;
        wait_cnt = 0;
        req_run = 0;
      end else if (buf_req_out) begin
        req_run++;
        if (req_run > max_req_run) max_req_run = req_run;
        if (wait_cnt < hold_cycles) begin
          wait_cnt++;
          buf_valid_in   = 1'b0;
          left_block_in  = '1;
          right_block_in = '0;
        end else begin
          check("req_left_x", int'(left_x_req_out), cur_x);
          check("req_y", int'(y_req_out), cur_y);
          buf_valid_in   = 1'b1;
          left_block_in  = mk_left(cur_mode, cur_seed);
          right_block_in = mk_right(cur_mode, cur_seed, cur_x - int'(right_x_req_out));
          wait_cnt = 0;
          req_count++;
          rx_log.push_back(int'(right_x_req_out));
        end
      end else begin
        req_run = 0;
        buf_valid_in   = 1'b1;
        left_block_in  = {6{48'h00FF_00FF_00FF}};
        right_block_in = {6{48'hFF00_FF00_FF00}};
      end
    end
  end

  // Scoreboard / result monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (valid_out) begin
        n_valid++;
        check("valid_one_cycle", int'(prev_valid), 0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 expected=0");
        end else begin
          e = sb_q.pop_front();
          check("disparity", int'(disparity_out), e.disp);
          check("min_sad", int'(min_sad_out), e.sad);
          check("disp_valid", int'(disp_valid_out), e.conf);
        end
      end
      prev_valid = valid_out;
    end
  end

  task automatic start_search(input int x, input int y, input int mode, input int seed, input int hold);
    cur_x = x; cur_y = y; cur_mode = mode; cur_seed = seed; hold_cycles = hold;
    req_count = 0; max_req_run = 0;
    rx_log.delete();
    @(negedge clk_in);
    start_in = 1'b1;
    x_in = 9'(x);
    y_in = 10'(y);
    @(negedge clk_in);
    start_in = 1'b0;
    x_in = '0;
    y_in = '0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int bd, bs, nv0, nreq;
    bit done;
    model(v.x, v.mode, v.seed, bd, bs);
    e.disp = v.use_const ? v.edisp : bd;
    e.sad  = v.use_const ? v.esad  : bs;
    e.conf = conf_of(e.sad);
    sb_q.push_back(e);
    nv0 = n_valid;
    start_search(v.x, v.y, v.mode, v.seed, v.hold);
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_in);
      #1;
      if (n_valid != nv0) done = 1'b1;
    end
    check("result_timeout", int'(done), 1);
    nreq = ((v.x < MD - 1) ? v.x : MD - 1) + 1;
    check("request_count", req_count, nreq);
    for (int i = 0; i < rx_log.size(); i++) check("right_x", rx_log[i], v.x - i);
    check("req_hold_run", max_req_run, v.hold + 1);
    repeat (2) @(negedge clk_in);
    check("idle_busy", int'(busy_out), 0);
  endtask

  vec_t vecs[10];

  initial begin
    int nv0;
    bit got;
    vec_t v;

    vecs[0] = '{x:100, y:20,  mode:0, seed:1,  hold:0,  use_const:1, edisp:0, esad:0};
    vecs[1] = '{x:100, y:21,  mode:1, seed:2,  hold:0,  use_const:1, edisp:5, esad:0};
    vecs[2] = '{x:3,   y:22,  mode:3, seed:7,  hold:0,  use_const:0, edisp:0, esad:0};
    vecs[3] = '{x:50,  y:23,  mode:2, seed:0,  hold:0,  use_const:1, edisp:0, esad:9180};
    vecs[4] = '{x:100, y:24,  mode:1, seed:2,  hold:20, use_const:1, edisp:5, esad:0};
    vecs[5] = '{x:0,   y:0,   mode:3, seed:3,  hold:0,  use_const:0, edisp:0, esad:0};
    vecs[6] = '{x:15,  y:999, mode:3, seed:4,  hold:2,  use_const:0, edisp:0, esad:0};
    vecs[7] = '{x:511, y:512, mode:3, seed:5,  hold:0,  use_const:0, edisp:0, esad:0};
    vecs[8] = '{x:9,   y:7,   mode:3, seed:9,  hold:1,  use_const:0, edisp:0, esad:0};
    vecs[9] = '{x:4,   y:8,   mode:1, seed:6,  hold:0,  use_const:0, edisp:0, esad:0};

    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_busy", int'(busy_out), 0);
    check("rst_buf_req", int'(buf_req_out), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_disparity", int'(disparity_out), 0);
    check("rst_min_sad", int'(min_sad_out), 0);
    check("rst_disp_valid", int'(disp_valid_out), 0);
    check("rst_right_x", int'(right_x_req_out), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("idle_busy_after_rst", int'(busy_out), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort in the middle of accumulating d=7.
    nv0 = n_valid;
    start_search(100, 30, 3, 11, 0);
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk_in);
      #1;
      if (req_count == 8) got = 1'b1;
    end
    check("abort_reach_d7", int'(got), 1);
    @(negedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("abort_busy", int'(busy_out), 0);
    check("abort_buf_req", int'(buf_req_out), 0);
    check("abort_valid", int'(valid_out), 0);
    check("abort_disparity", int'(disparity_out), 0);
    check("abort_min_sad", int'(min_sad_out), 0);
    check("abort_disp_valid", int'(disp_valid_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (40) @(negedge clk_in);
    check("abort_no_valid", n_valid, nv0);

    v = '{x:100, y:30, mode:3, seed:11, hold:0, use_const:0, edisp:0, esad:0};
    run_vec(v);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
